// File: rtl/drp_sensor_responder.sv
// DRP slave for a sensor front end: holds the latest converter sample plus two
// config registers, and answers each accepted request exactly LATENCY cycles later.
module drp_sensor_responder #(
   parameter int unsigned LATENCY   = 4,
   parameter logic [6:0]  DATA_ADDR = 7'h15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        den,
   input  logic        dwe,
   input  logic [6:0]  daddr,
   input  logic [15:0] di,
   output logic [15:0] do_out,
   output logic        drdy,
   output logic        busy,
   input  logic [11:0] sample_in,
   input  logic        sample_valid,
   output logic        eoc
);

   localparam logic [6:0] STATUS_ADDR = 7'h3F;
   localparam logic [6:0] CFG0_ADDR   = 7'h40;
   localparam logic [6:0] CFG1_ADDR   = 7'h41;
   // WAIT lasts LATENCY-1 cycles; the counter expires on its zero value.
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic [6:0]  r_addr;
   logic        r_we;
   logic [15:0] r_di;
   logic [15:0] r_rdata;
   logic        r_clr_ns;
   logic        r_clr_ov;
   logic [11:0] r_sample;
   logic [15:0] r_cfg0;
   logic [15:0] r_cfg1;
   logic        r_new_sample;
   logic        r_overrun;
   logic        r_eoc;

   logic [15:0] w_rd_val;
   logic        w_accept;
   logic        w_ovr_set;
   logic        w_ack;

   assign w_accept  = (r_state == IDLE) && den;
   assign w_ovr_set = (r_state != IDLE) && den;
   assign w_ack     = (r_state == ACK);

   always_comb begin
      w_rd_val = 16'h0000;
      if (daddr == DATA_ADDR)        w_rd_val = {r_sample, 4'b0000};
      else if (daddr == STATUS_ADDR) w_rd_val = {14'b0, r_new_sample, r_overrun};
      else if (daddr == CFG0_ADDR)   w_rd_val = r_cfg0;
      else if (daddr == CFG1_ADDR)   w_rd_val = r_cfg1;
   end

   // NOTE: every output and next-state signal gets a default first, so no latch can be inferred.
   always_comb begin
      w_next = r_state;
      drdy   = 1'b0;
      busy   = 1'b1;
      do_out = 16'h0000;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (den) w_next = (LATENCY == 1) ? ACK : WAIT;
         end
         WAIT: if (r_cnt == 4'd0) w_next = ACK;
         ACK: begin
            drdy   = 1'b1;
            do_out = r_rdata;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign eoc = r_eoc;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= 4'd0;
         r_addr       <= 7'd0;
         r_we         <= 1'b0;
         r_di         <= 16'h0000;
         r_rdata      <= 16'h0000;
         r_clr_ns     <= 1'b0;
         r_clr_ov     <= 1'b0;
         r_sample     <= 12'h000;
         r_cfg0       <= 16'h0000;
         r_cfg1       <= 16'h0000;
         r_new_sample <= 1'b0;
         r_overrun    <= 1'b0;
         r_eoc        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_eoc   <= sample_valid;
         if (sample_valid) r_sample <= sample_in;

         if (w_accept) begin
            r_cnt    <= CNT_INIT;
            r_addr   <= daddr;
            r_we     <= dwe;
            r_di     <= di;
            r_rdata  <= dwe ? 16'h0000 : w_rd_val;
            // A flag may only be cleared if it has not been re-set since it was read.
            r_clr_ns <= !dwe && (daddr == DATA_ADDR) && !sample_valid;
            r_clr_ov <= !dwe && (daddr == STATUS_ADDR);
         end else begin
            if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (sample_valid) r_clr_ns <= 1'b0;
            if (w_ovr_set)    r_clr_ov <= 1'b0;
         end

         if (sample_valid)           r_new_sample <= 1'b1;
         else if (w_ack && r_clr_ns) r_new_sample <= 1'b0;

         if (w_ovr_set)              r_overrun <= 1'b1;
         else if (w_ack && r_clr_ov) r_overrun <= 1'b0;

         if (w_ack && r_we) begin
            if (r_addr == CFG0_ADDR) r_cfg0 <= r_di;
            if (r_addr == CFG1_ADDR) r_cfg1 <= r_di;
         end
      end
   end

endmodule

// File: tb/tb_drp_sensor_responder.sv
// Directed bench for drp_sensor_responder: a per-cycle vector table for LATENCY=4
// plus hand sequences for reset corners and a LATENCY=1 instance.
module tb_drp_sensor_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        den, dwe, sample_valid;
   logic [6:0]  daddr;
   logic [15:0] di;
   logic [11:0] sample_in;
   logic [15:0] do4, do1;
   logic        drdy4, busy4, eoc4, drdy1, busy1, eoc1;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   drp_sensor_responder #(.LATENCY(4), .DATA_ADDR(7'h15)) dut4 (
      .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
      .do_out(do4), .drdy(drdy4), .busy(busy4),
      .sample_in(sample_in), .sample_valid(sample_valid), .eoc(eoc4));

   drp_sensor_responder #(.LATENCY(1), .DATA_ADDR(7'h15)) dut1 (
      .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
      .do_out(do1), .drdy(drdy1), .busy(busy1),
      .sample_in(sample_in), .sample_valid(sample_valid), .eoc(eoc1));

   typedef struct {
      logic        den;
      logic        dwe;
      logic [6:0]  addr;
      logic [15:0] di;
      logic        sv;
      logic [11:0] si;
      logic        e_drdy;
      logic [15:0] e_do;
      logic        e_busy;
      logic        e_eoc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic den_i, logic dwe_i, logic [6:0] a, logic [15:0] d,
                              logic sv_i, logic [11:0] si_i, logic e_drdy,
                              logic [15:0] e_do, logic e_busy, logic e_eoc);
      vec_t r;
      r.den = den_i; r.dwe = dwe_i; r.addr = a; r.di = d; r.sv = sv_i; r.si = si_i;
      r.e_drdy = e_drdy; r.e_do = e_do; r.e_busy = e_busy; r.e_eoc = e_eoc;
      return r;
   endfunction

   // One full LATENCY=4 transaction: request, two WAIT cycles, ACK, idle turnaround.
   function automatic void req(logic we, logic [6:0] a, logic [15:0] d, logic [15:0] e_do);
      vecs.push_back(v(1, we, a, d, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, e_do, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0));
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(logic den_i, logic dwe_i, logic [6:0] a, logic [15:0] d,
                       logic sv_i, logic [11:0] si_i);
      den = den_i; dwe = dwe_i; daddr = a; di = d; sample_valid = sv_i; sample_in = si_i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      den = 0; dwe = 0; daddr = 0; di = 0; sample_valid = 0; sample_in = 0;

      // Requests and samples presented during reset must be ignored.
      step(1, 1, 7'h40, 16'hFFFF, 1, 12'hABC);
      step(1, 0, 7'h15, 16'h0, 0, 0);
      check("rst drdy4", 16'(drdy4), 16'h0);
      check("rst busy4", 16'(busy4), 16'h0);
      check("rst eoc4", 16'(eoc4), 16'h0);
      check("rst do4", do4, 16'h0);
      check("rst busy1", 16'(busy1), 16'h0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);
      check("post-rst busy4", 16'(busy4), 16'h0);
      check("post-rst eoc4", 16'(eoc4), 16'h0);

      // Sample capture, data read, status read.
      vecs.push_back(v(0, 0, 0, 0, 1, 12'h370, 0, 16'h0, 0, 1));
      req(0, 7'h15, 16'h0, 16'h3700);
      req(0, 7'h3F, 16'h0, 16'h0000);
      // cfg0 write/readback, write to read-only data register.
      req(1, 7'h40, 16'hA5C3, 16'h0000);
      req(0, 7'h40, 16'h0, 16'hA5C3);
      req(1, 7'h15, 16'hFFFF, 16'h0000);
      req(0, 7'h15, 16'h0, 16'h3700);
      // den while busy: ignored, only one drdy, overrun set then cleared by read.
      vecs.push_back(v(1, 0, 7'h00, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(1, 0, 7'h41, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0));
      req(0, 7'h3F, 16'h0, 16'h0001);
      req(0, 7'h3F, 16'h0, 16'h0000);
      // Same-cycle sample and data read: old data returned, new_sample survives.
      vecs.push_back(v(1, 0, 7'h15, 0, 1, 12'h550, 0, 16'h0, 1, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'h3700, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0));
      req(0, 7'h3F, 16'h0, 16'h0002);
      req(0, 7'h15, 16'h0, 16'h5500);
      req(0, 7'h3F, 16'h0, 16'h0000);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].den, vecs[i].dwe, vecs[i].addr, vecs[i].di, vecs[i].sv, vecs[i].si);
         check($sformatf("v%0d drdy", i), 16'(drdy4), 16'(vecs[i].e_drdy));
         check($sformatf("v%0d do_out", i), do4, vecs[i].e_do);
         check($sformatf("v%0d busy", i), 16'(busy4), 16'(vecs[i].e_busy));
         check($sformatf("v%0d eoc", i), 16'(eoc4), 16'(vecs[i].e_eoc));
      end

      // Reset in WAIT of a cfg1 write: no drdy, write dropped.
      step(1, 1, 7'h41, 16'h1234, 0, 0);
      check("abort busy", 16'(busy4), 16'h1);
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      check("abort idle", 16'(busy4), 16'h0);
      check("abort drdy", 16'(drdy4), 16'h0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0);
         check($sformatf("abort quiet%0d", k), 16'(drdy4), 16'h0);
      end
      step(1, 0, 7'h41, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("cfg1 rd drdy", 16'(drdy4), 16'h1);
      check("cfg1 rd data", do4, 16'h0000);
      step(0, 0, 0, 0, 0, 0);

      // LATENCY=1: back-to-back unmapped reads every two cycles.
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 7'h00, 0, 0, 0);
         check($sformatf("l1 drdy%0d", k), 16'(drdy1), 16'h1);
         check($sformatf("l1 do%0d", k), do1, 16'h0000);
         step(0, 0, 0, 0, 0, 0);
         check($sformatf("l1 gap%0d", k), 16'(drdy1), 16'h0);
         check($sformatf("l1 gap busy%0d", k), 16'(busy1), 16'h0);
      end
      step(1, 0, 7'h3F, 0, 0, 0);
      check("l1 status drdy", 16'(drdy1), 16'h1);
      check("l1 status", do1, 16'h0000);
      step(0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
